// File: rtl/event_if.sv
// event_if: event handshake between event_capture (master) and the convolution core (slave)
interface event_if #(parameter int EW = 21);
  logic          event_valid;
  logic [EW-1:0] event_data;
  logic          conv_ready;
  logic          conv_ack;
  modport master(output event_valid, event_data, input conv_ready, conv_ack);
  modport slave(input event_valid, event_data, output conv_ready, conv_ack);
endinterface

// File: rtl/event_capture.sv
// event_capture: filters and queues spike events, offering them one at a time to the convolution core
module event_capture #(
  parameter int BITS_PER_COORDINATE = 8,
  parameter int IN_CHANNELS = 4,
  parameter int IMG_WIDTH = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int EW = 1 + 2 * BITS_PER_COORDINATE + IN_CHANNELS,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_timestep,
  input  logic [BITS_PER_COORDINATE-1:0] in_x,
  input  logic [BITS_PER_COORDINATE-1:0] in_y,
  input  logic [IN_CHANNELS-1:0]         in_spikes,
  event_if.master                        ev,
  output logic [CW-1:0]                  fifo_count,
  output logic                           empty,
  output logic                           full,
  output logic [15:0]                    drop_count
);
  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic ok, hs, push, pop;
  assign ok = |in_spikes && 32'(in_x) < 32'(IMG_WIDTH) && 32'(in_y) < 32'(IMG_HEIGHT);
  assign hs = in_valid && in_ready;
  assign push = hs && ok;
  assign pop = state == OFFER && ev.conv_ack;
  assign empty = fifo_count == '0;
  assign full = fifo_count == CW'(FIFO_DEPTH);
  assign in_ready = !full;
  assign ev.event_valid = state == OFFER;
  // head stays put until the ack pops it, so the offer is stable for free
  assign ev.event_data = empty ? '0 : mem[rd_ptr];
  always_comb begin
    state_nx = (state == IDLE && !empty && ev.conv_ready) ? OFFER :
               (state == OFFER && ev.conv_ack) ? BUSY :
               (state == BUSY && ev.conv_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_timestep, in_x, in_y, in_spikes};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (hs && !ok && drop_count != '1) drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: doc/event_capture.md
# event_capture

Buffers incoming spike events and delivers them one at a time to the convolution core over the `event_if` handshake (`event_valid`, `event_data`, `conv_ready`, `conv_ack`). It is the producer end of that interface and sits between the upstream spike source and `Convolution2d`. A new event is never offered while a previous one is still being convolved. Internally it is a synchronous show-ahead FIFO, a three-state dispatch FSM and status counters.

## Interface
- `BITS_PER_COORDINATE`, 8, width of x and y.
- `IN_CHANNELS`, 4, spike vector width.
- `IMG_WIDTH`, 32, events with x ≥ IMG_WIDTH are rejected.
- `IMG_HEIGHT`, 32, events with y ≥ IMG_HEIGHT are rejected.
- `FIFO_DEPTH`, 16, entries; power of two, ≥ 2.
- `EW` (local), 1+2·BITS_PER_COORDINATE+IN_CHANNELS, event width.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the upstream event is valid.
- `in_ready` out 1: the block can accept an event; equals `!full`.
- `in_timestep` in 1: timestep parity bit.
- `in_x`, `in_y` in BITS_PER_COORDINATE: event coordinate.
- `in_spikes` in IN_CHANNELS: per-input-channel spike mask.
- `event_valid` out 1: an event is offered to the convolution core.
- `event_data` out EW: the offered event, packed {timestep, x, y, spikes}, with timestep as the MSB.
- `conv_ready` in 1: the convolution core is idle.
- `conv_ack` in 1: one-cycle pulse; the convolution core has latched `event_data`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `empty`, `full` out 1: FIFO flags.
- `drop_count` out 16: count of rejected events; saturates at 0xFFFF.

## Operation
- Push: occurs on `in_valid && in_ready` when the event is acceptable. An event is acceptable when `in_spikes != 0`, x < IMG_WIDTH and y < IMG_HEIGHT.
- Rejected handshake: an unacceptable event is still handshaken (`in_ready` obeyed). It is not stored, and `drop_count` is incremented.
- Full FIFO: when full, `in_ready` = 0. There is no bypass, so a push is not accepted in the same cycle as a pop while full.
- Pop: occurs on the `conv_ack` cycle while in OFFER.
- Simultaneous push and pop: `fifo_count` is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Head entry: always driven on `event_data`, whether or not `event_valid` is high. When empty, `event_data` = 0.
- FSM states:
  - IDLE → OFFER when `!empty && conv_ready`.
  - OFFER: `event_valid` = 1 and `event_data` is held stable. On `conv_ack` the block pops and goes to BUSY.
  - BUSY → IDLE when `conv_ready` = 1. The convolution core drops `conv_ready` in the cycle of the ack and raises it again when done.
- `conv_ack` outside OFFER: ignored, no pop.
- `conv_ready` falling in OFFER without an ack: the block stays in OFFER with `event_valid` held. Offers are never withdrawn.
- Dispatch order: strict FIFO. Timestep parity is passed through unchanged.

## Timing
- Reset values: `in_ready` 1, `event_valid` 0, `event_data` 0, `fifo_count` 0, `empty` 1, `full` 0, `drop_count` 0, state IDLE.
- Reset mid-operation: the FIFO contents are discarded and the FSM returns to IDLE. A pending ack is ignored.
- Latency, push to offer (empty FIFO, `conv_ready` = 1): a push at edge N gives `empty` = 0 after N. The FSM enters OFFER at N+1, so `event_valid` is high in the cycle after N+1.
- Ack to next offer: an ack at edge A makes the state BUSY after A. The minimum time from ack to the next offer is 2 cycles after `conv_ready` returns high.
- Flags and counters: `fifo_count`, `empty`, `full` and `drop_count` are registered and update on the edge of the push or pop.
- Throughput: at most 1 push per cycle and at most 1 dispatch per convolution.

## Test plan
- Single event:
  - Stimulus: push {ts=1, x=5, y=7, spikes=4'b0101} with `conv_ready` = 1.
  - Response: `event_valid` rises 2 cycles after the push, with `event_data` matching exactly.
  - Then: an ack pulse gives BUSY and `empty` = 1. Hold `conv_ready` = 0 for 20 cycles, then release it. No re-offer occurs.
- Fill to full:
  - Stimulus: 17 back-to-back pushes with DEPTH = 16 and `conv_ready` = 0.
  - Response: `full` = 1 and `in_ready` = 0 after the 16th push. `fifo_count` = 16 and the 17th event is not accepted.
  - Then: drain with acks. The 16 events come out in order, with values x = 0..15.
- Rejects:
  - Stimulus: push spikes = 0, then x = 32, then y = 40.
  - Response: `drop_count` = 3 and `fifo_count` = 0. `event_valid` never rises.
- Stall in OFFER:
  - Stimulus: while an event is offered, drop `conv_ready` for 5 cycles with no ack.
  - Response: `event_valid` stays 1 with `event_data` unchanged. The ack then pops exactly one entry.
- Simultaneous push and pop:
  - Stimulus: with `fifo_count` = 3, a push and an ack occur in the same cycle.
  - Response: `fifo_count` = 3 and the ordering is preserved.
  - Also: a spurious `conv_ack` in IDLE changes nothing.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle while in OFFER with 5 entries queued.
  - Response: the next cycle shows `event_valid` 0, `empty` 1, `fifo_count` 0 and `drop_count` 0.
